// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hold/flush controller: hold levels, FSM states, helpers.
package pipe_ctrl_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        HOLD_NONE = 3'd0,
        HOLD_PC   = 3'd1,
        HOLD_IF   = 3'd2,
        HOLD_ID   = 3'd3
    } hold_e;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    // The deepest requested hold wins; levels are ordered numerically.
    function automatic hold_e hold_max(input hold_e a, input hold_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hold/flush request and response bundle between the pipeline stages and pipe_ctrl.
interface pipe_ctrl_if;

    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_ex_i;
    logic        hold_flag_clint_i;
    logic        hold_flag_rib_i;
    logic        jtag_halt_req_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        halt_ack_o;
    logic        bus_timeout_o;

    modport slave (
        input  jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_clint_i,
               hold_flag_rib_i, jtag_halt_req_i,
        output hold_flag_o, jump_flag_o, jump_addr_o, halt_ack_o, bus_timeout_o
    );

    modport master (
        output jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_clint_i,
               hold_flag_rib_i, jtag_halt_req_i,
        input  hold_flag_o, jump_flag_o, jump_addr_o, halt_ack_o, bus_timeout_o
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating run-length counter: counts consecutive cycles of inc_i, clears on a gap.
module sat_counter #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    output logic hit_o
);

    localparam logic [WIDTH-1:0] LIM      = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] LIM_LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (!inc_i) begin
            count_q <= '0;
        end else if (count_q != LIM) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    // Fires on the last cycle of a full LIMIT-long run.
    assign hit_o = inc_i && (count_q == LIM_LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: arbitrates stall sources into the Hold_Flag_Bus and
// sequences post-jump flushes, drained JTAG halts and a rib-stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned RIB_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    localparam int unsigned FCW = $clog2(FLUSH_CYCLES) + 1;
    localparam int unsigned RCW = $clog2(RIB_TIMEOUT) + 1;
    localparam logic [FCW-1:0] FLUSH_RELOAD =
        FCW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    state_e          state_q, state_d;
    logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
    logic            bus_timeout_q;
    logic            rib_hit;
    logic            stage_busy;
    logic            id_req;
    hold_e           hold_lvl;

    assign stage_busy = bus.hold_flag_ex_i || bus.hold_flag_clint_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_RUN;
            flush_cnt_q   <= '0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            if (rib_hit) bus_timeout_q <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            S_RUN: begin
                if (bus.jump_flag_i && (FLUSH_CYCLES > 1)) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (bus.jtag_halt_req_i) begin
                    state_d = stage_busy ? S_DRAIN : S_HALT;
                end
            end
            S_FLUSH: begin
                // A new jump restarts the bubble window; halt waits until S_RUN.
                if (bus.jump_flag_i) begin
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (flush_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FCW'(1);
                end
            end
            S_DRAIN: begin
                if (!bus.jtag_halt_req_i) begin
                    state_d = S_RUN;
                end else if (!stage_busy) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (!bus.jtag_halt_req_i) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    sat_counter #(
        .WIDTH (RCW),
        .LIMIT (RIB_TIMEOUT)
    ) u_rib_wdog (
        .clk   (clk),
        .rst   (rst),
        .inc_i (bus.hold_flag_rib_i),
        .hit_o (rib_hit)
    );

    assign id_req = bus.jump_flag_i || stage_busy || (state_q != S_RUN);

    always_comb begin
        hold_lvl = hold_max(id_req ? HOLD_ID : HOLD_NONE,
                            bus.hold_flag_rib_i ? HOLD_PC : HOLD_NONE);
        if (!rst) hold_lvl = HOLD_NONE;
    end

    // Outputs are forced to their reset values while reset is asserted, even mid-jump.
    assign bus.hold_flag_o   = hold_lvl;
    assign bus.jump_flag_o   = rst && bus.jump_flag_i;
    assign bus.jump_addr_o   = bus.jump_flag_o ? bus.jump_addr_i : ZERO_WORD;
    assign bus.halt_ack_o    = (state_q == S_HALT);
    assign bus.bus_timeout_o = bus_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic against a run-length model.
module tb_pipe_ctrl;

    localparam int FC = 2;
    localparam int RT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: remaining bubbles, halt mode (0 none, 1 draining, 2 halted), rib run length.
    int   flush_left = 0;
    int   halt_mode  = 0;
    int   rib_run    = 0;
    bit   tmo        = 1'b0;

    pipe_ctrl_if bus();

    pipe_ctrl #(.FLUSH_CYCLES(FC), .RIB_TIMEOUT(RT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit j, input logic [31:0] a, input bit ex, input bit cl,
                         input bit rb, input bit hr);
        bus.jump_flag_i       = j;
        bus.jump_addr_i       = a;
        bus.hold_flag_ex_i    = ex;
        bus.hold_flag_clint_i = cl;
        bus.hold_flag_rib_i   = rb;
        bus.jtag_halt_req_i   = hr;
    endtask

    task automatic model_reset();
        flush_left = 0;
        halt_mode  = 0;
        rib_run    = 0;
        tmo        = 1'b0;
    endtask

    task automatic step(input bit j, input logic [31:0] a, input bit ex, input bit cl,
                        input bit rb, input bit hr);
        int exp_hold;
        @(negedge clk);
        drive(j, a, ex, cl, rb, hr);
        #1;
        exp_hold = (j || flush_left > 0 || ex || cl || halt_mode != 0) ? 3 : (rb ? 1 : 0);
        check("hold_flag", 32'(bus.hold_flag_o), 32'(exp_hold));
        check("jump_flag", 32'(bus.jump_flag_o), 32'(j));
        check("jump_addr", bus.jump_addr_o, j ? a : 32'h0);
        check("halt_ack", 32'(bus.halt_ack_o), 32'(halt_mode == 2));
        check("bus_timeout", 32'(bus.bus_timeout_o), 32'(tmo));
        @(posedge clk);
        if (rb) rib_run++; else rib_run = 0;
        if (rib_run >= RT) tmo = 1'b1;
        case (halt_mode)
            0: begin
                if (j) flush_left = FC - 1;
                else if (flush_left > 0) flush_left--;
                else if (hr) halt_mode = (ex || cl) ? 1 : 2;
            end
            1: begin
                if (!hr) halt_mode = 0;
                else if (!ex && !cl) halt_mode = 2;
            end
            default: if (!hr) halt_mode = 0;
        endcase
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        #1;
        check({tag, "_hold"}, 32'(bus.hold_flag_o), 32'h0);
        check({tag, "_jflag"}, 32'(bus.jump_flag_o), 32'h0);
        check({tag, "_jaddr"}, bus.jump_addr_o, 32'h0);
        check({tag, "_ack"}, 32'(bus.halt_ack_o), 32'h0);
        check({tag, "_tmo"}, 32'(bus.bus_timeout_o), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
    endtask

    initial begin
        bit j, ex, cl, rb, hr;
        drive(0, 0, 0, 0, 0, 0);
        do_reset("reset");

        // Single jump, then back-to-back jumps.
        step(1, 32'h100, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(1, 32'h200, 0, 0, 0, 0);
        step(1, 32'h300, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // Halt with drain behind a 5-cycle ex hold, then withdraw.
        repeat (5) step(0, 0, 1, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);

        // Halt requested while flushing is deferred to S_RUN; withdrawn during drain.
        step(1, 32'hdead_beef, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        step(1, 32'h44, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);

        // Rib watchdog: run one short of the limit, a gap, then a full run.
        repeat (RT - 1) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        repeat (RT + 3) step(0, 0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // Rib plus clint together, then clint drops.
        do_reset("reset2");
        repeat (3) step(0, 0, 0, 1, 1, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a flush and of a halt.
        step(1, 32'h500, 0, 0, 0, 0);
        do_reset("reset_flush");
        step(0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 1);
        do_reset("reset_halt");
        step(0, 0, 0, 0, 0, 0);

        // Random traffic with persistent levels; no jump is ever driven while halted.
        {ex, cl, rb, hr} = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0)  ex = ~ex;
            if ($urandom_range(11) == 0) cl = ~cl;
            if ($urandom_range(9) == 0)  rb = ~rb;
            if ($urandom_range(19) == 0) hr = ~hr;
            j = ($urandom_range(5) == 0) && (halt_mode != 2);
            step(j, $urandom, ex, cl, rb, hr);
            if (i == 1500) begin
                do_reset("reset_rand");
                {ex, cl, rb, hr} = '0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
